// File: rtl/traffic_light_fsm_if.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm_if
//   Groups the signals between the intersection controller and its
//   environment: the interval timer (expiry flags in, restart out), the side
//   road car sensor and the lamp drivers.
//
//   car_sensor   side road vehicle present (level)
//   tMG/tMY      main green / main yellow interval expired (from timer)
//   tSG/tSY      side green / side yellow interval expired (from timer)
//   start        timer restart, wired to the timer's sync reset
//   main_lights  {red, yellow, green} for the main road
//   side_lights  {red, yellow, green} for the side road
//   fault        watchdog fault latched
//
//   master: the controller (drives start, lamps, fault)
//   slave : timer / sensor / lamp side
// -----------------------------------------------------------------------------
interface traffic_light_fsm_if;
    logic       car_sensor;
    logic       tMG;
    logic       tMY;
    logic       tSG;
    logic       tSY;
    logic       start;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       fault;

    modport master (
        input  car_sensor, tMG, tMY, tSG, tSY,
        output start, main_lights, side_lights, fault
    );

    modport slave (
        output car_sensor, tMG, tMY, tSG, tSY,
        input  start, main_lights, side_lights, fault
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
//   Moore controller for a main/side road intersection. Sequences the lamps
//   MG -> MY -> SG -> SY -> MG using expiry flags from an external interval
//   timer, latches side road car requests, and runs a per-state watchdog that
//   drops into a flashing-yellow FAULT state if the timer stops reporting.
//
//   clk         rising-edge clock
//   sync_reset  synchronous, active-high reset
//   bus         traffic_light_fsm_if.master (sensor, expiry flags, start,
//               main/side lamps, fault)
//
//   WD_W       watchdog counter width
//   WD_LIMIT   cycles allowed per timed interval (2 <= WD_LIMIT < 2**WD_W)
//   FLASH_DIV  cycles per half-period of the fault flash (>= 1)
// -----------------------------------------------------------------------------
module traffic_light_fsm #(
    parameter int unsigned WD_W      = 8,
    parameter int unsigned WD_LIMIT  = 200,
    parameter int unsigned FLASH_DIV = 4
) (
    input  logic                clk,
    input  logic                sync_reset,
    traffic_light_fsm_if.master bus
);

    localparam int unsigned     FC_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_DIV - 1);

    typedef enum logic [2:0] {
        S_MG,
        S_MY,
        S_SG,
        S_SY,
        S_FAULT
    } state_t;

    state_t          state_q,     state_d;
    logic            start_q,     start_d;
    logic            done_q,      done_d;
    logic            car_req_q,   car_req_d;
    logic            flash_q,     flash_d;
    logic            fault_q,     fault_d;
    logic [WD_W-1:0] wd_cnt_q,    wd_cnt_d;
    logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]      main_q,      main_d;
    logic [2:0]      side_q,      side_d;

    logic v_mg, v_my, v_sg, v_sy;
    logic advance;
    logic waiting;
    logic wd_expired;

    always_comb begin
        // Flags seen during the start cycle still reflect the old timer count.
        v_mg = bus.tMG && !start_q;
        v_my = bus.tMY && !start_q;
        v_sg = bus.tSG && !start_q;
        v_sy = bus.tSY && !start_q;

        state_d     = state_q;
        advance     = 1'b0;
        done_d      = done_q;
        car_req_d   = car_req_q;
        wd_cnt_d    = wd_cnt_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        main_d      = main_q;
        side_d      = side_q;

        unique case (state_q)
            S_MG: if ((done_q || v_mg) && (car_req_q || bus.car_sensor)) begin
                state_d = S_MY;
                advance = 1'b1;
            end
            S_MY: if (v_my) begin
                state_d = S_SG;
                advance = 1'b1;
            end
            S_SG: if (v_sg) begin
                state_d = S_SY;
                advance = 1'b1;
            end
            S_SY: if (v_sy) begin
                state_d = S_MG;
                advance = 1'b1;
            end
            default: ;
        endcase

        // Green interval already served in MG: waiting for a car is not a fault,
        // including the very cycle the expiry arrives.
        waiting    = (state_q == S_MG) && (done_q || v_mg);
        wd_expired = (state_q != S_FAULT) && !start_q && (wd_cnt_q == WD_LAST)
                     && !waiting && !advance;
        if (wd_expired) begin
            state_d = S_FAULT;
        end

        if (state_d != state_q) begin
            done_d = 1'b0;
        end else if ((state_q == S_MG) && v_mg) begin
            done_d = 1'b1;
        end

        // Entry to SG consumes the request; sensor is only watched in MG/MY.
        if ((state_q == S_MY) && (state_d == S_SG)) begin
            car_req_d = 1'b0;
        end else if (((state_q == S_MG) || (state_q == S_MY)) && bus.car_sensor) begin
            car_req_d = 1'b1;
        end

        if (start_q) begin
            wd_cnt_d = '0;
        end else if (!((state_q == S_MG) && done_q) && (state_q != S_FAULT)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
            flash_d     = 1'b0;
            flash_cnt_d = '0;
        end else if (state_q == S_FAULT) begin
            if (flash_cnt_q == FC_LAST) begin
                flash_cnt_d = '0;
                flash_d     = !flash_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end

        start_d = (state_d != state_q) && (state_d != S_FAULT);
        fault_d = (state_d == S_FAULT);

        // Lamps are registered from the next state so they line up with state_q.
        unique case (state_d)
            S_MG: begin
                main_d = 3'b001;
                side_d = 3'b100;
            end
            S_MY: begin
                main_d = 3'b010;
                side_d = 3'b100;
            end
            S_SG: begin
                main_d = 3'b100;
                side_d = 3'b001;
            end
            S_SY: begin
                main_d = 3'b100;
                side_d = 3'b010;
            end
            S_FAULT: begin
                main_d = {1'b0, flash_d, 1'b0};
                side_d = {1'b0, flash_d, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q     <= S_MG;
            start_q     <= 1'b1;
            done_q      <= 1'b0;
            car_req_q   <= 1'b0;
            wd_cnt_q    <= '0;
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
            fault_q     <= 1'b0;
            main_q      <= 3'b001;
            side_q      <= 3'b100;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            done_q      <= done_d;
            car_req_q   <= car_req_d;
            wd_cnt_q    <= wd_cnt_d;
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
            fault_q     <= fault_d;
            main_q      <= main_d;
            side_q      <= side_d;
        end
    end

    assign bus.start       = start_q;
    assign bus.main_lights = main_q;
    assign bus.side_lights = side_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;

    localparam int unsigned WD_W      = 8;
    localparam int unsigned WD_LIMIT  = 10;
    localparam int unsigned FLASH_DIV = 2;

    logic clk = 1'b0;
    logic sync_reset;
    always #5 clk = ~clk;

    traffic_light_fsm_if bus();

    traffic_light_fsm #(
        .WD_W      (WD_W),
        .WD_LIMIT  (WD_LIMIT),
        .FLASH_DIV (FLASH_DIV)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: phase index into the lamp table, age in phase,
    // watchdog tally, fault age for the flash pattern.
    // ------------------------------------------------------------------
    logic [2:0] MAIN_TBL [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] SIDE_TBL [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

    int m_phase     = 0;
    int m_age       = 0;
    int m_wd        = 0;
    int m_fault_age = 0;
    bit m_fault     = 0;
    bit m_done      = 0;
    bit m_req       = 0;
    bit m_valid     = 0;

    always @(posedge clk) begin : model
        bit         st;
        bit         own;
        bit         adv;
        bit         idle_ok;
        logic [3:0] flags;
        if (sync_reset) begin
            m_phase = 0; m_age = 0; m_wd = 0; m_fault = 0;
            m_done = 0; m_req = 0; m_fault_age = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_fault) begin
                m_fault_age++;
            end else begin
                flags   = {bus.tMG, bus.tMY, bus.tSG, bus.tSY};
                st      = (m_age == 0);
                own     = flags[3 - m_phase] && !st;
                adv     = (m_phase == 0) ? ((m_done || own) && (m_req || bus.car_sensor)) : own;
                idle_ok = (m_phase == 0) && (m_done || own);
                if (m_phase < 2 && bus.car_sensor) m_req = 1;
                if (adv) begin
                    m_phase = (m_phase + 1) % 4;
                    m_age = 0; m_done = 0; m_wd = 0;
                    if (m_phase == 2) m_req = 0;
                end else if (!st && m_wd == WD_LIMIT - 1 && !idle_ok) begin
                    m_fault = 1;
                    m_fault_age = 0;
                end else begin
                    if (!st && !m_done) m_wd++;
                    if (m_phase == 0 && own) m_done = 1;
                    if (m_age < 100000) m_age++;
                end
            end
        end
    end

    function automatic logic [7:0] model_out();
        logic fl;
        if (m_fault) begin
            fl = ((m_fault_age / FLASH_DIV) % 2) == 1;
            return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0, 1'b0, 1'b1};
        end
        return {MAIN_TBL[m_phase], SIDE_TBL[m_phase], (m_age == 0), 1'b0};
    endfunction

    always @(negedge clk) begin : compare
        logic [7:0] got;
        logic [7:0] exp;
        if (m_valid) begin
            got = {bus.main_lights, bus.side_lights, bus.start, bus.fault};
            exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got main/side/start/fault=%b required=%b",
                         $time, got, exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic io(input logic r, input logic car, input logic [3:0] f);
        @(negedge clk);
        sync_reset     = r;
        bus.car_sensor = car;
        {bus.tMG, bus.tMY, bus.tSG, bus.tSY} = f;
    endtask

    task automatic do_reset(input int n);
        repeat (n) io(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic lit(input string name, input logic [2:0] em, input logic [2:0] es,
                       input logic est, input logic ef);
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] mdl;
        exp = {em, es, est, ef};
        got = {bus.main_lights, bus.side_lights, bus.start, bus.fault};
        mdl = model_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut got=%b required=%b", name, got, exp);
        end
        checks++;
        if (mdl !== exp) begin
            errors++;
            $display("FAIL %s model got=%b required=%b", name, mdl, exp);
        end
    endtask

    initial begin
        int p;
        logic [3:0] fr;
        sync_reset     = 1'b1;
        bus.car_sensor = 1'b0;
        {bus.tMG, bus.tMY, bus.tSG, bus.tSY} = 4'b0000;

        // A: no car, tMG at cycle 10 -> stays MG, start only in cycle 0.
        do_reset(3);
        for (int c = 0; c < 20; c++) begin
            io(1'b0, 1'b0, (c == 10) ? 4'b1000 : 4'b0000);
            if (c == 0) lit("A_start", 3'b001, 3'b100, 1'b1, 1'b0);
            else if (c == 10 || c == 11 || c == 19) lit("A_hold", 3'b001, 3'b100, 1'b0, 1'b0);
        end

        // B: latched 1-cycle car, full cycle, request cleared by SG entry.
        do_reset(2);
        for (int c = 0; c < 22; c++) begin
            fr = (c == 6)  ? 4'b1000 : (c == 9)  ? 4'b0100 :
                 (c == 13) ? 4'b0010 : (c == 16) ? 4'b0001 :
                 (c == 19) ? 4'b1000 : 4'b0000;
            io(1'b0, (c == 3), fr);
            case (c)
                7:  lit("B_MY",       3'b010, 3'b100, 1'b1, 1'b0);
                8:  lit("B_MY_hold",  3'b010, 3'b100, 1'b0, 1'b0);
                10: lit("B_SG",       3'b100, 3'b001, 1'b1, 1'b0);
                14: lit("B_SY",       3'b100, 3'b010, 1'b1, 1'b0);
                17: lit("B_MG",       3'b001, 3'b100, 1'b1, 1'b0);
                20: lit("B_req_clr",  3'b001, 3'b100, 1'b0, 1'b0);
                default: ;
            endcase
        end

        // C: same-cycle car+tMG; tMY during start ignored, one cycle later taken.
        do_reset(2);
        for (int c = 0; c < 8; c++) begin
            fr = (c == 3) ? 4'b1000 : (c == 4 || c == 5) ? 4'b0100 : 4'b0000;
            io(1'b0, (c == 3), fr);
            case (c)
                4: lit("C_MY",       3'b010, 3'b100, 1'b1, 1'b0);
                5: lit("C_start_ign", 3'b010, 3'b100, 1'b0, 1'b0);
                6: lit("C_SG",       3'b100, 3'b001, 1'b1, 1'b0);
                default: ;
            endcase
        end

        // D: MY starved -> FAULT 10 cycles after start falls, flash by 2, reset exits.
        do_reset(2);
        for (int c = 0; c < 22; c++) begin
            if (c == 1)       io(1'b0, 1'b1, 4'b1000);
            else if (c == 20) io(1'b1, 1'b0, 4'b0000);
            else if (c >= 13) io(1'b0, 1'($urandom_range(0, 1)), (c == 15) ? 4'b0100 : 4'($urandom));
            else              io(1'b0, 1'b0, 4'b0000);
            case (c)
                2:  lit("D_MY",     3'b010, 3'b100, 1'b1, 1'b0);
                12: lit("D_prefault", 3'b010, 3'b100, 1'b0, 1'b0);
                13: lit("D_fault0", 3'b000, 3'b000, 1'b0, 1'b1);
                14: lit("D_fault1", 3'b000, 3'b000, 1'b0, 1'b1);
                15: lit("D_fault2", 3'b010, 3'b010, 1'b0, 1'b1);
                16: lit("D_fault3", 3'b010, 3'b010, 1'b0, 1'b1);
                17: lit("D_fault4", 3'b000, 3'b000, 1'b0, 1'b1);
                19: lit("D_fault6", 3'b010, 3'b010, 1'b0, 1'b1);
                21: lit("D_reset",  3'b001, 3'b100, 1'b1, 1'b0);
                default: ;
            endcase
        end

        // E: reset mid-SG (with car present) -> MG, no stale request.
        do_reset(2);
        for (int c = 0; c < 11; c++) begin
            fr = (c == 1) ? 4'b1000 : (c == 3) ? 4'b0100 : (c == 8) ? 4'b1000 : 4'b0000;
            io((c == 6), (c == 1 || c == 5 || c == 6), fr);
            case (c)
                4:  lit("E_SG",      3'b100, 3'b001, 1'b1, 1'b0);
                7:  lit("E_reset",   3'b001, 3'b100, 1'b1, 1'b0);
                9:  lit("E_no_req",  3'b001, 3'b100, 1'b0, 1'b0);
                default: ;
            endcase
        end

        // Random episodes with varying flag density; occasional reset.
        for (int ep = 0; ep < 40; ep++) begin
            case ($urandom_range(0, 3))
                0: p = 2;
                1: p = 4;
                2: p = 8;
                default: p = 20;
            endcase
            do_reset(1 + $urandom_range(0, 2));
            for (int k = 0; k < 60; k++) begin
                fr[3] = ($urandom_range(0, p - 1) == 0);
                fr[2] = ($urandom_range(0, p - 1) == 0);
                fr[1] = ($urandom_range(0, p - 1) == 0);
                fr[0] = ($urandom_range(0, p - 1) == 0);
                io(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), fr);
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Moore-style controller for the main/side road intersection. It sits directly downstream of the traffic interval timer: it consumes the timer's expiry flags `tMG`, `tMY`, `tSG` and `tSY`, and drives the timer's `start` (sync reset) input. It sequences the main and side road lamps, latches side road car requests, and runs a per-state watchdog. If the timer stops reporting, the watchdog drops the intersection into a flashing-yellow fault state.

## Interface
- `WD_W`, 8: watchdog counter width.
- `WD_LIMIT`, 200: cycles allowed per timed interval before fault; must satisfy 2 ≤ `WD_LIMIT` < 2^`WD_W`.
- `FLASH_DIV`, 4: cycles per half-period of the fault flash; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `sync_reset`  in  1  synchronous, active-high reset.
- `car_sensor`  in  1  side road vehicle present (level).
- `tMG`  in  1  main green interval expired (from timer).
- `tMY`  in  1  main yellow interval expired.
- `tSG`  in  1  side green interval expired.
- `tSY`  in  1  side yellow interval expired.
- `start`  out  1  timer restart, wired to the timer's sync reset.
- `main_lights`  out  3  {red, yellow, green}, registered.
- `side_lights`  out  3  {red, yellow, green}, registered.
- `fault`  out  1  watchdog fault latched.

## Operation
- States and lamps:
  - MG: main 001, side 100.
  - MY: main 010, side 100.
  - SG: main 100, side 001.
  - SY: main 100, side 010.
  - FAULT: main {0,flash,0}, side {0,flash,0}.
- Reset: state MG, `start`=1, `fault`=0, `car_req`=0, `done_q`=0, `wd_cnt`=0, `flash`=0.
- `start` is registered:
  - High throughout `sync_reset` and in the first cycle after reset releases.
  - High for exactly one cycle, the first cycle of each newly entered state.
  - Otherwise 0.
- Valid expiry: a flag counts only when `start`=0 in that same cycle. Flags seen while `start`=1 reflect the old timer count and are ignored.
- `car_req`:
  - Set when `car_sensor`=1 in MG or MY.
  - Cleared on entry to SG.
  - Sensor activity in SG or SY is ignored.
- MG:
  - A valid `tMG` sets `done_q`. `done_q` is cleared on any state entry.
  - Transition to MY when (`done_q` or valid `tMG`) and (`car_req` or `car_sensor`).
  - With no request, MG holds indefinitely without restarting the timer.
- MY goes to SG on a valid `tMY`.
- SG goes to SY on a valid `tSG`.
- SY goes to MG on a valid `tSY`.
- Flags other than the current state's own flag are ignored.
- Watchdog:
  - `wd_cnt` clears while `start`=1 and increments each cycle otherwise.
  - It stops counting in MG once `done_q` is set, since waiting for a car is not a fault.
  - If `wd_cnt` reaches `WD_LIMIT`-1 in a cycle with no transition, the next state is FAULT.
  - A transition in that same cycle takes priority over FAULT.
- FAULT:
  - `fault`=1 and `start`=0.
  - `flash` toggles every `FLASH_DIV` cycles, starting at 0 on entry.
  - All inputs are ignored; only `sync_reset` exits FAULT.

## Timing
- Expiry-to-lamp latency is 1 cycle. A valid flag in cycle n gives the new state, lamps and `start`=1 in cycle n+1.
- The earliest next expiry is accepted in cycle n+2.
- A `car_sensor` pulse of one cycle in MG or MY is sufficient: it is latched.
- Fault onset: FAULT lamps and `fault`=1 appear `WD_LIMIT` non-start cycles after `start` falls, provided no valid expiry occurred.
- `sync_reset` asserted in any state, including FAULT, forces reset values on the next edge.

## Test plan
- Reset held 3 cycles, then released, with no car; `tMG` pulsed at cycle 10 → `start`=1 only in the first post-reset cycle; state stays MG (001/100); no further `start`; `fault`=0 forever.
- 1-cycle `car_sensor` in MG at cycle 5, then `tMG` at cycle 12 → cycle 13: MY (010/100), `start`=1; `tMY` at 20 → SG (100/001) at 21; `tSG` at 30 → SY (100/010) at 31; `tSY` at 35 → MG at 36; `car_req`=0 after SG entry.
- `tMG` and `car_sensor` asserted in the same cycle in MG (no prior request) → MY next cycle.
- In MY, `tMY` asserted during the `start`=1 cycle only → no transition; the same flag one cycle later → SG.
- With `WD_LIMIT`=10 and `FLASH_DIV`=2, hold MY with no `tMY` → `fault`=1 exactly 10 cycles after `start` falls; lamps go 000,000 / 010,010 alternating every 2 cycles; a later `tMY` has no effect; reset returns to MG (001/100).
- Reset asserted mid-SG → MG, `start`=1, `car_req`=0 on the next edge.
